// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the SoC reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        S_WAIT_LOCK   = 2'd0,
        S_PERIPH_HOLD = 2'd1,
        S_CPU_HOLD    = 2'd2,
        S_RUN         = 2'd3
    } seq_state_e;

    localparam int CAUSE_W    = 4;
    localparam int CAUSE_BTN  = 0;
    localparam int CAUSE_SW   = 1;
    localparam int CAUSE_WDOG = 2;
    localparam int CAUSE_PLL  = 3;

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces the raw reset button. Emits a one-cycle pulse
// on each debounced press.
module button_debounce #(
    parameter int DEBOUNCE_W = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    output logic btn_level,
    output logic btn_press
);

    logic                  meta_q;
    logic                  sync_q;
    logic                  level_q;
    logic                  level_d;
    logic                  press_q;
    logic                  press_d;
    logic [DEBOUNCE_W-1:0] cnt_q;
    logic [DEBOUNCE_W-1:0] cnt_d;

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync_q != level_q) begin
            if (&cnt_q) begin
                level_d = sync_q;
                press_d = sync_q;
            end else begin
                cnt_d = cnt_q + DEBOUNCE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= button_raw;
            sync_q  <= meta_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset sequencer: waits for PLL lock, releases peripherals then the CPU,
// and restarts on button, software, watchdog or lock-loss events.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 64,
    parameter int DEBOUNCE_W  = 16,
    parameter int WDOG_W      = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               button_raw,
    input  logic               pll_lock,
    input  logic               sw_reset_req,
    input  logic               wdog_en,
    input  logic               wdog_kick,
    output logic               periph_reset_n,
    output logic               cpu_reset_n,
    output logic               ready,
    output logic [CAUSE_W-1:0] reset_cause
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    seq_state_e         state_q;
    seq_state_e         state_d;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [HOLD_W-1:0]  hold_cnt_d;
    logic [WDOG_W-1:0]  wdog_cnt_q;
    logic [WDOG_W-1:0]  wdog_cnt_d;
    logic [CAUSE_W-1:0] cause_q;
    logic [CAUSE_W-1:0] cause_d;
    logic [CAUSE_W-1:0] run_fire;
    logic [CAUSE_W-1:0] hold_fire;
    logic               periph_q;
    logic               periph_d;
    logic               cpu_q;
    logic               cpu_d;
    logic               lock_meta_q;
    logic               lock_s_q;
    logic               btn_press;
    logic               btn_level_unused;
    logic               hold_done;
    logic               hold_abort;
    logic               wdog_expired;

    button_debounce #(
        .DEBOUNCE_W (DEBOUNCE_W)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .button_raw (button_raw),
        .btn_level  (btn_level_unused),
        .btn_press  (btn_press)
    );

    assign hold_done    = (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1));
    assign hold_abort   = btn_press || !lock_s_q;
    // A kick landing on the terminal-count cycle wins over the timeout.
    assign wdog_expired = (state_q == S_RUN) && wdog_en && (&wdog_cnt_q) && !wdog_kick;

    always_comb begin
        run_fire             = '0;
        run_fire[CAUSE_BTN]  = btn_press;
        run_fire[CAUSE_SW]   = sw_reset_req;
        run_fire[CAUSE_WDOG] = wdog_expired;
        run_fire[CAUSE_PLL]  = !lock_s_q;
        hold_fire            = '0;
        hold_fire[CAUSE_BTN] = btn_press;
        hold_fire[CAUSE_PLL] = !lock_s_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_WAIT_LOCK;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // Next-state logic; the hold counter is cleared on every state change.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        case (state_q)
            S_WAIT_LOCK: begin
                if (lock_s_q) state_d = S_PERIPH_HOLD;
            end
            S_PERIPH_HOLD: begin
                if (hold_abort)     state_d = S_WAIT_LOCK;
                else if (hold_done) state_d = S_CPU_HOLD;
                else                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            S_CPU_HOLD: begin
                if (hold_abort)     state_d = S_WAIT_LOCK;
                else if (hold_done) state_d = S_RUN;
                else                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            S_RUN: begin
                if (|run_fire) state_d = S_WAIT_LOCK;
            end
            default: state_d = S_WAIT_LOCK;
        endcase
    end

    // Output logic: reset levels follow the next state so they are registered
    // on the same edge as the transition.
    always_comb begin
        periph_d = (state_d == S_CPU_HOLD) || (state_d == S_RUN);
        cpu_d    = (state_d == S_RUN);
        cause_d  = cause_q;
        case (state_q)
            S_RUN: begin
                if (|run_fire) cause_d = run_fire;
            end
            S_PERIPH_HOLD, S_CPU_HOLD: begin
                cause_d = cause_q | hold_fire;
            end
            default: cause_d = cause_q;
        endcase
    end

    always_comb begin
        wdog_cnt_d = '0;
        if ((state_q == S_RUN) && (state_d == S_RUN) && wdog_en && !wdog_kick) begin
            wdog_cnt_d = (&wdog_cnt_q) ? wdog_cnt_q : wdog_cnt_q + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            wdog_cnt_q  <= '0;
            cause_q     <= '0;
            periph_q    <= 1'b0;
            cpu_q       <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            wdog_cnt_q  <= wdog_cnt_d;
            cause_q     <= cause_d;
            periph_q    <= periph_d;
            cpu_q       <= cpu_d;
        end
    end

    assign periph_reset_n = periph_q;
    assign cpu_reset_n    = cpu_q;
    assign ready          = cpu_q;
    assign reset_cause    = cause_q;

endmodule
